// File: rtl/pulse_extender.sv
// Retriggerable pulse stretcher: pulse_out stays high for PULSE_LENGTH cycles after the
// last high sample of pulse_in. Output is taken straight from a flop.
module pulse_extender #(
    parameter int PULSE_LENGTH = 2
) (
    input  logic clock,
    input  logic resetn,
    input  logic pulse_in,
    output logic pulse_out
);

    // Guarded so an illegal PULSE_LENGTH still elaborates far enough to report the error.
    localparam int CountWidth = (PULSE_LENGTH < 1) ? 1 : $clog2(PULSE_LENGTH + 1);
    localparam logic [CountWidth-1:0] Reload = CountWidth'(PULSE_LENGTH - 1);

    if (PULSE_LENGTH < 1) begin : g_bad_length
        $error("pulse_extender: PULSE_LENGTH must be at least 1");
    end

    logic [CountWidth-1:0] count_q, count_d;
    logic                  pulse_d;

    always_comb begin
        count_d = count_q;
        pulse_d = 1'b0;
        if (pulse_in) begin
            count_d = Reload;
            pulse_d = 1'b1;
        end else if (count_q != '0) begin
            count_d = count_q - CountWidth'(1);
            pulse_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            pulse_out <= 1'b0;
        end else begin
            count_q   <= count_d;
            pulse_out <= pulse_d;
        end
    end

endmodule

// File: tb/tb_pulse_extender.sv
// Scoreboard bench for pulse_extender: four instances (PULSE_LENGTH 1, 2, 3, 8) share one
// input; expected outputs are queued per cycle and compared by an independent monitor.
module tb_pulse_extender;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pulse_in = 1'b0;
    logic [3:0] outs;  // {pl8, pl3, pl2, pl1}

    pulse_extender #(.PULSE_LENGTH(1)) u_pl1 (
        .clock(clock), .resetn(resetn), .pulse_in(pulse_in), .pulse_out(outs[0]));
    pulse_extender #(.PULSE_LENGTH(2)) u_pl2 (
        .clock(clock), .resetn(resetn), .pulse_in(pulse_in), .pulse_out(outs[1]));
    pulse_extender #(.PULSE_LENGTH(3)) u_pl3 (
        .clock(clock), .resetn(resetn), .pulse_in(pulse_in), .pulse_out(outs[2]));
    pulse_extender #(.PULSE_LENGTH(8)) u_pl8 (
        .clock(clock), .resetn(resetn), .pulse_in(pulse_in), .pulse_out(outs[3]));

    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [3:0] exp;
    } entry_t;

    entry_t     sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] hist = '0;
    bit         run_chk = 1'b0;
    int         run_len[4] = '{0, 0, 0, 0};

    function automatic int pl_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            default: return 8;
        endcase
    endfunction

    // Window model: output high iff any of the last PULSE_LENGTH samples was high.
    function automatic logic [3:0] window_model(input logic [7:0] h);
        logic [3:0] m;
        for (int i = 0; i < 4; i++) begin
            int msk = (1 << pl_of(i)) - 1;
            m[i] = ((int'(h) & msk) != 0);
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b ({pl8,pl3,pl2,pl1})",
                     name, $time, act, exp);
        end
    endtask

    // exp2 < 0 means take the PL=2 expectation from the model as well.
    task automatic cycle(input string name, input logic in_bit, input int exp2);
        entry_t e;
        @(negedge clock);
        pulse_in = in_bit;
        hist     = {hist[6:0], in_bit};
        e.name   = name;
        e.exp    = window_model(hist);
        if (exp2 >= 0) e.exp[1] = exp2[0];
        sb.push_back(e);
    endtask

    task automatic run_vec(input string name, input string vin, input string vexp);
        for (int i = 0; i < vin.len(); i++) begin
            cycle(name, vin[i] == "1", (vexp[i] == "1") ? 1 : 0);
        end
    endtask

    // Monitor: every cycle the DUTs present a fresh registered output.
    entry_t mon_e;
    always @(posedge clock) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk(mon_e.name, outs, mon_e.exp);
        end
        if (run_chk) begin
            for (int i = 0; i < 4; i++) begin
                if (outs[i]) begin
                    run_len[i]++;
                end else begin
                    if (run_len[i] > 0) begin
                        checks++;
                        if (run_len[i] < pl_of(i)) begin
                            errors++;
                            $display("FAIL min_width pl=%0d: run of %0d, required >= %0d",
                                     pl_of(i), run_len[i], pl_of(i));
                        end
                    end
                    run_len[i] = 0;
                end
            end
        end
    end

    initial begin
        // Reset holds outputs low even with pulse_in high.
        resetn   = 1'b0;
        pulse_in = 1'b1;
        repeat (2) @(posedge clock);
        #1 chk("reset_state", outs, 4'b0000);
        @(negedge clock);
        pulse_in = 1'b0;
        resetn   = 1'b1;
        hist     = '0;

        run_vec("idle",        "0000",   "0000");
        run_vec("single",      "100000", "110000");
        run_vec("long",        "111100000", "111110000");
        run_vec("repeated",    "101010100000000000", "111111110000000000");
        run_vec("gap_2",       "10010000", "11011000");
        run_vec("pad",         "0000000000", "0000000000");
        run_vec("sweep",       "1000000000", "1100000000");

        // Reset mid-pulse: outputs drop asynchronously, no residual extension.
        cycle("mr_rise", 1'b1, 1);
        @(posedge clock);
        #2 resetn = 1'b0;
        #1 chk("async_reset", outs, 4'b0000);
        pulse_in = 1'b1;
        @(posedge clock);
        #1 chk("reset_ignores_in", outs, 4'b0000);
        @(negedge clock);
        pulse_in = 1'b0;
        resetn   = 1'b1;
        hist     = '0;
        run_vec("after_reset", "000000", "000000");
        run_vec("post_reset_pulse", "100000000", "110000000");

        // Random burst at probability 1/2, then a quiet tail.
        run_chk = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            cycle("random", ($urandom_range(1, 0) == 0), -1);
        end
        for (int i = 0; i < 1000; i++) begin
            cycle("random_tail", 1'b0, -1);
        end
        @(posedge clock);
        #2;
        run_chk = 1'b0;
        chk("final_low", outs, 4'b0000);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drained: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_extender.md
Name: pulse_extender

Overview:
- Stretches every input pulse so the output stays high for at least PULSE_LENGTH clock cycles.
- Used to widen short strobes (single-cycle events, glitches, interrupt pulses) for slower consumers or for crossing into slower logic.
- Single clock domain.
- Output is registered and retriggerable: any high input sample restarts the hold window.

Parameters:
- PULSE_LENGTH, default 2: minimum output pulse width in clock cycles. Also the number of cycles the output stays high after the last high input sample. Legal range is ≥ 1; a value of 0 is a compile-time error (elaboration assertion).

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- resetn  input  1  reset, asynchronous assert and active-low; clears all state.
- pulse_in  input  1  pulse to extend; level-sensitive, sampled on each rising clock edge.
- pulse_out  output  1  extended pulse; driven directly from a flop.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (ports clock and resetn).
- State:
  - Down-counter `count` of width $clog2(PULSE_LENGTH+1).
  - Registered output flop `pulse_out`.
- Reset (resetn low, asynchronous): count = 0, pulse_out = 0. Both stay 0 while resetn is low, regardless of pulse_in.
- Each rising edge with resetn high:
  - If pulse_in = 1: count <= PULSE_LENGTH-1, pulse_out <= 1.
  - Else if count != 0: count <= count-1, pulse_out <= 1.
  - Else: pulse_out <= 0, count stays 0.
- Latency:
  - pulse_out rises one edge after pulse_in is sampled high: it is high immediately after the first edge at which pulse_in = 1.
  - No combinational path from pulse_in to pulse_out.
- Width rules:
  - A pulse_in held high for N consecutive sampled cycles gives a single output pulse of exactly N + PULSE_LENGTH − 1 cycles.
  - For N = 1 this is exactly PULSE_LENGTH cycles.
  - The output never produces a high pulse shorter than PULSE_LENGTH.
- Retrigger: a new input high while the output is still high reloads the counter. Output pulses merge, with no low gap, whenever the input gap is shorter than PULSE_LENGTH cycles.
- Output gap: after the final hold cycle pulse_out returns low and stays low until pulse_in is next sampled high.
- PULSE_LENGTH = 1: the block reduces to a single register (pulse_out = pulse_in delayed by one cycle).
- Reset mid-pulse: pulse_out drops to 0 asynchronously and count clears. After reset deasserts, pulse_in is sampled from the next rising edge with no residual extension.
- Reset release: release is taken to be synchronized externally; no internal reset synchronizer.
- Counter never wraps: saturates at 0, and reload values never exceed PULSE_LENGTH-1.

Test Plan:
- Single 1-cycle pulse (PULSE_LENGTH=2): pulse_in high for one edge -> pulse_out high exactly 2 cycles starting after that edge, then low; low at the end of a 6-cycle window.
- Long pulse: pulse_in high for 4 consecutive edges -> one output pulse of 4+2−1 = 5 cycles, no gaps, low afterwards.
- Repeated 1-cycle pulses: 4 pulses separated by one low cycle -> output merges into one continuous pulse of 8 cycles (last rise + 2), never narrower than 2; low at the end of an 18-cycle window.
- Reset mid-pulse: assert resetn low while pulse_out is high -> pulse_out goes 0 immediately (asynchronous). After release with pulse_in low, pulse_out stays 0.
- Random stimulus: 1000 cycles with pulse_in high at probability 1/PULSE_LENGTH, then input low -> every high run of pulse_out is ≥ PULSE_LENGTH cycles, and pulse_out is low by the end of a 2000-cycle window.
- Parameter sweep (PULSE_LENGTH = 1, 3, 8): a single 1-cycle input pulse gives an output pulse of exactly PULSE_LENGTH cycles.
